// File: rtl/dm_abs_cmd_pkg.sv
// Shared definitions for the Debug Module abstract command engine:
// command field positions, cmderr codes and the engine state encoding.
package dm_abs_cmd_pkg;

  localparam int CMD_CMDTYPE_LSB  = 24;
  localparam int CMD_CMDTYPE_MSB  = 31;
  localparam int CMD_AARSIZE_LSB  = 20;
  localparam int CMD_AARSIZE_MSB  = 22;
  localparam int CMD_POSTEXEC_BIT = 18;
  localparam int CMD_TRANSFER_BIT = 17;
  localparam int CMD_WRITE_BIT    = 16;
  localparam int CMD_REGNO_LSB    = 0;
  localparam int CMD_REGNO_MSB    = 15;

  // Only 32-bit register accesses are supported.
  localparam logic [2:0] AARSIZE_32 = 3'd2;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } abs_state_e;

endpackage

// File: rtl/dm_abs_cmd.sv
// Abstract command engine: executes Access Register commands against the
// halted core over a req/rsp handshake and reports busy/cmderr.
// Optional watchdog enabled by defining DM_ABS_CMD_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for cmd_update; validates and accepts commands
// ISSUE    | reg_req_valid held high until the core signals ready
// WAIT_RSP | request accepted, waiting for reg_rsp_valid
// DONE     | one-cycle completion, busy still high
module dm_abs_cmd
  import dm_abs_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGNO_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [DATA_WIDTH-1:0]  command,
  input  logic                   cmd_update,
  input  logic [DATA_WIDTH-1:0]  data0,
  input  logic                   hart_halted,
  input  logic                   cmderr_clr,
  output logic                   busy,
  output logic [2:0]             cmderr,
  output logic                   data0_wr_en,
  output logic [DATA_WIDTH-1:0]  data0_wr_data,
  output logic                   reg_req_valid,
  input  logic                   reg_req_ready,
  output logic [REGNO_WIDTH-1:0] reg_req_addr,
  output logic                   reg_req_we,
  output logic [DATA_WIDTH-1:0]  reg_req_wdata,
  input  logic                   reg_rsp_valid,
  input  logic [DATA_WIDTH-1:0]  reg_rsp_rdata,
  input  logic                   reg_rsp_err
);

  abs_state_e state;

  logic [7:0]             cmd_type;
  logic [2:0]             cmd_aarsize;
  logic                   cmd_postexec;
  logic                   cmd_transfer;
  logic                   cmd_write;
  logic [REGNO_WIDTH-1:0] cmd_regno;
  logic                   cmd_unsupported;
  logic                   rsp_take;
  logic                   timeout_hit;
  logic                   unused_bits;

  assign cmd_type        = command[CMD_CMDTYPE_MSB:CMD_CMDTYPE_LSB];
  assign cmd_aarsize     = command[CMD_AARSIZE_MSB:CMD_AARSIZE_LSB];
  assign cmd_postexec    = command[CMD_POSTEXEC_BIT];
  assign cmd_transfer    = command[CMD_TRANSFER_BIT];
  assign cmd_write       = command[CMD_WRITE_BIT];
  assign cmd_regno       = command[REGNO_WIDTH-1:0];
  assign cmd_unsupported = (cmd_type != 8'd0) || (cmd_aarsize != AARSIZE_32) || cmd_postexec;

  // A response arriving together with ready in ISSUE is handled like WAIT_RSP.
  assign rsp_take = reg_rsp_valid &&
                    ((state == ST_WAIT_RSP) || ((state == ST_ISSUE) && reg_req_ready));

`ifdef DM_ABS_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;

  // Watchdog: cleared in IDLE, counts every cycle spent on the core handshake.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else if ((state == ST_ISSUE) || (state == ST_WAIT_RSP)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = ((state == ST_ISSUE) || (state == ST_WAIT_RSP)) &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !rsp_take;
  assign unused_bits = ^{command[23], command[19]};
`else
  assign timeout_hit = 1'b0;
  assign unused_bits = ^{command[23], command[19], TIMEOUT_CYCLES[0]};
`endif

  // Command FSM; later assignments take priority, so an error set beats cmderr_clr.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      cmderr        <= CMDERR_NONE;
      data0_wr_en   <= 1'b0;
      data0_wr_data <= '0;
      reg_req_valid <= 1'b0;
      reg_req_addr  <= '0;
      reg_req_we    <= 1'b0;
      reg_req_wdata <= '0;
    end else begin
      data0_wr_en <= 1'b0;

      if (cmderr_clr) begin
        cmderr <= CMDERR_NONE;
      end
      if (cmd_update && busy && (cmderr == CMDERR_NONE)) begin
        cmderr <= CMDERR_BUSY;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_update && (cmderr == CMDERR_NONE)) begin
            if (cmd_unsupported) begin
              cmderr <= CMDERR_NOTSUP;
            end else if (!hart_halted) begin
              cmderr <= CMDERR_HALTRESUME;
            end else if (!cmd_transfer) begin
              busy  <= 1'b1;
              state <= ST_DONE;
            end else begin
              reg_req_addr  <= cmd_regno;
              reg_req_we    <= cmd_write;
              reg_req_wdata <= data0;
              reg_req_valid <= 1'b1;
              busy          <= 1'b1;
              state         <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (reg_req_ready) begin
            reg_req_valid <= 1'b0;
            state         <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy          <= 1'b0;
          reg_req_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase

      if (rsp_take) begin
        if (reg_rsp_err) begin
          cmderr <= CMDERR_EXCEPT;
        end else if (!reg_req_we) begin
          data0_wr_en   <= 1'b1;
          data0_wr_data <= reg_rsp_rdata;
        end
        state <= ST_DONE;
      end

      if (timeout_hit) begin
        cmderr        <= CMDERR_EXCEPT;
        reg_req_valid <= 1'b0;
        state         <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_dm_abs_cmd.sv
// Directed self-checking bench for dm_abs_cmd.
module tb_dm_abs_cmd;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] command = '0;
  logic        cmd_update = 1'b0;
  logic [31:0] data0 = '0;
  logic        hart_halted = 1'b0;
  logic        cmderr_clr = 1'b0;
  logic        busy;
  logic [2:0]  cmderr;
  logic        data0_wr_en;
  logic [31:0] data0_wr_data;
  logic        reg_req_valid;
  logic        reg_req_ready = 1'b0;
  logic [15:0] reg_req_addr;
  logic        reg_req_we;
  logic [31:0] reg_req_wdata;
  logic        reg_rsp_valid = 1'b0;
  logic [31:0] reg_rsp_rdata = '0;
  logic        reg_rsp_err = 1'b0;

  int checks = 0;
  int failures = 0;

  dm_abs_cmd #(
    .DATA_WIDTH(32),
    .REGNO_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .command(command),
    .cmd_update(cmd_update),
    .data0(data0),
    .hart_halted(hart_halted),
    .cmderr_clr(cmderr_clr),
    .busy(busy),
    .cmderr(cmderr),
    .data0_wr_en(data0_wr_en),
    .data0_wr_data(data0_wr_data),
    .reg_req_valid(reg_req_valid),
    .reg_req_ready(reg_req_ready),
    .reg_req_addr(reg_req_addr),
    .reg_req_we(reg_req_we),
    .reg_req_wdata(reg_req_wdata),
    .reg_rsp_valid(reg_rsp_valid),
    .reg_rsp_rdata(reg_rsp_rdata),
    .reg_rsp_err(reg_rsp_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    checks++;
    if ({busy, cmderr, data0_wr_en, reg_req_valid, reg_req_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {busy, cmderr, data0_wr_en, reg_req_valid, reg_req_we}, 7'b0);
    end
    checks++;
    if ({reg_req_addr, reg_req_wdata, data0_wr_data} !== 80'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {reg_req_addr, reg_req_wdata, data0_wr_data});
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int busy_cnt;
    hart_halted = 1'b1;
    reg_req_ready = 1'b1;
    command = 32'h0022_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    busy_cnt = int'(busy);
    checks++;
    if ({reg_req_valid, reg_req_we, reg_req_addr} !== {1'b1, 1'b0, 16'h1005}) begin
      failures++;
      $display("FAIL read_req got=%b/%b/%h exp=1/0/1005", reg_req_valid, reg_req_we, reg_req_addr);
    end
    tick();
    busy_cnt += int'(busy);
    checks++;
    if (reg_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_valid_drop got=%b exp=0", reg_req_valid);
    end
    reg_rsp_valid = 1'b1;
    reg_rsp_rdata = 32'hDEAD_BEEF;
    tick();
    reg_rsp_valid = 1'b0;
    busy_cnt += int'(busy);
    checks++;
    if ({data0_wr_en, data0_wr_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL read_data0 got=%b/%h exp=1/deadbeef", data0_wr_en, data0_wr_data);
    end
    tick();
    checks++;
    if ({busy, data0_wr_en, cmderr} !== 5'b0) begin
      failures++;
      $display("FAIL read_end got=%b/%b/%0d exp=0/0/0", busy, data0_wr_en, cmderr);
    end
    checks++;
    if (busy_cnt !== 3) begin
      failures++;
      $display("FAIL read_busy_cycles got=%0d exp=3", busy_cnt);
    end
  endtask

  task automatic test_write();
    reg_req_ready = 1'b0;
    data0 = 32'h1234_5678;
    command = 32'h0023_1001;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    data0 = 32'hFFFF_0000;
    checks++;
    if ({reg_req_valid, reg_req_we, reg_req_addr, reg_req_wdata} !== {1'b1, 1'b1, 16'h1001, 32'h1234_5678}) begin
      failures++;
      $display("FAIL write_req got=%b/%b/%h/%h exp=1/1/1001/12345678", reg_req_valid, reg_req_we, reg_req_addr, reg_req_wdata);
    end
    tick();
    checks++;
    if ({reg_req_valid, reg_req_wdata} !== {1'b1, 32'h1234_5678}) begin
      failures++;
      $display("FAIL write_stall_stable got=%b/%h exp=1/12345678", reg_req_valid, reg_req_wdata);
    end
    reg_req_ready = 1'b1;
    tick();
    reg_rsp_valid = 1'b1;
    reg_rsp_rdata = 32'h5555_AAAA;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if ({busy, data0_wr_en} !== 2'b10) begin
      failures++;
      $display("FAIL write_no_data0 got=%b/%b exp=1/0", busy, data0_wr_en);
    end
    tick();
    checks++;
    if ({busy, cmderr} !== 4'b0) begin
      failures++;
      $display("FAIL write_end got=%b/%0d exp=0/0", busy, cmderr);
    end
  endtask

  task automatic test_notsup();
    command = 32'h0032_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    checks++;
    if ({busy, cmderr} !== {1'b0, 3'd2}) begin
      failures++;
      $display("FAIL notsup_err got=%b/%0d exp=0/2", busy, cmderr);
    end
    command = 32'h0022_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    checks++;
    if ({busy, reg_req_valid, cmderr} !== {2'b00, 3'd2}) begin
      failures++;
      $display("FAIL notsup_ignored got=%b/%b/%0d exp=0/0/2", busy, reg_req_valid, cmderr);
    end
    cmderr_clr = 1'b1;
    tick();
    cmderr_clr = 1'b0;
    checks++;
    if (cmderr !== 3'd0) begin
      failures++;
      $display("FAIL notsup_clr got=%0d exp=0", cmderr);
    end
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    checks++;
    if ({busy, reg_req_valid} !== 2'b11) begin
      failures++;
      $display("FAIL notsup_accept got=%b/%b exp=1/1", busy, reg_req_valid);
    end
    tick();
    reg_rsp_valid = 1'b1;
    tick();
    reg_rsp_valid = 1'b0;
    tick();
  endtask

  task automatic test_transfer0();
    command = 32'h0020_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    checks++;
    if ({busy, reg_req_valid} !== 2'b10) begin
      failures++;
      $display("FAIL notransfer_busy got=%b/%b exp=1/0", busy, reg_req_valid);
    end
    tick();
    checks++;
    if ({busy, data0_wr_en, cmderr} !== 5'b0) begin
      failures++;
      $display("FAIL notransfer_end got=%b/%b/%0d exp=0/0/0", busy, data0_wr_en, cmderr);
    end
  endtask

  task automatic test_halt_and_busy();
    hart_halted = 1'b0;
    command = 32'h0022_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    checks++;
    if ({busy, cmderr} !== {1'b0, 3'd4}) begin
      failures++;
      $display("FAIL halt_err got=%b/%0d exp=0/4", busy, cmderr);
    end
    cmderr_clr = 1'b1;
    hart_halted = 1'b1;
    reg_req_ready = 1'b0;
    tick();
    cmderr_clr = 1'b0;
    cmd_update = 1'b1;
    tick();
    checks++;
    if ({busy, reg_req_valid, cmderr} !== {2'b11, 3'd0}) begin
      failures++;
      $display("FAIL busy_first_accept got=%b/%b/%0d exp=1/1/0", busy, reg_req_valid, cmderr);
    end
    command = 32'h0023_0002;
    tick();
    cmd_update = 1'b0;
    checks++;
    if ({cmderr, reg_req_valid, reg_req_addr, reg_req_we} !== {3'd1, 1'b1, 16'h1005, 1'b0}) begin
      failures++;
      $display("FAIL busy_err got=%0d/%b/%h/%b exp=1/1/1005/0", cmderr, reg_req_valid, reg_req_addr, reg_req_we);
    end
    reg_req_ready = 1'b1;
    tick();
    reg_rsp_valid = 1'b1;
    reg_rsp_rdata = 32'hCAFE_0001;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if ({data0_wr_en, data0_wr_data, cmderr} !== {1'b1, 32'hCAFE_0001, 3'd1}) begin
      failures++;
      $display("FAIL busy_first_done got=%b/%h/%0d exp=1/cafe0001/1", data0_wr_en, data0_wr_data, cmderr);
    end
    cmderr_clr = 1'b1;
    tick();
    cmderr_clr = 1'b0;
    checks++;
    if ({busy, cmderr} !== 4'b0) begin
      failures++;
      $display("FAIL busy_end got=%b/%0d exp=0/0", busy, cmderr);
    end
  endtask

  task automatic test_rsp_err();
    reg_req_ready = 1'b1;
    command = 32'h0022_1007;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    tick();
    reg_rsp_valid = 1'b1;
    reg_rsp_err = 1'b1;
    reg_rsp_rdata = 32'h0BAD_0BAD;
    tick();
    reg_rsp_valid = 1'b0;
    reg_rsp_err = 1'b0;
    checks++;
    if ({busy, data0_wr_en, cmderr} !== {2'b10, 3'd3}) begin
      failures++;
      $display("FAIL rsp_err got=%b/%b/%0d exp=1/0/3", busy, data0_wr_en, cmderr);
    end
    cmderr_clr = 1'b1;
    tick();
    cmderr_clr = 1'b0;
    checks++;
    if ({busy, cmderr} !== 4'b0) begin
      failures++;
      $display("FAIL rsp_err_end got=%b/%0d exp=0/0", busy, cmderr);
    end
  endtask

  task automatic test_reset_mid();
    reg_req_ready = 1'b0;
    command = 32'h0022_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({busy, reg_req_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_issue got=%b/%b exp=0/0", busy, reg_req_valid);
    end
    #2;
    sys_rst = 1'b0;
    reg_req_ready = 1'b1;
    tick();
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    tick();
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({busy, reg_req_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait got=%b/%b exp=0/0", busy, reg_req_valid);
    end
    #2;
    sys_rst = 1'b0;
    reg_rsp_valid = 1'b1;
    reg_rsp_rdata = 32'h7777_7777;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if ({busy, data0_wr_en, cmderr} !== 5'b0) begin
      failures++;
      $display("FAIL rst_late_rsp got=%b/%b/%0d exp=0/0/0", busy, data0_wr_en, cmderr);
    end
  endtask

`ifdef DM_ABS_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int valid_cnt;
    valid_cnt = 0;
    reg_req_ready = 1'b0;
    command = 32'h0022_1005;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
    for (int i = 0; i < 40 && reg_req_valid; i++) begin
      valid_cnt++;
      tick();
    end
    checks++;
    if (valid_cnt !== 16) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d exp=16", valid_cnt);
    end
    checks++;
    if ({busy, cmderr} !== {1'b1, 3'd3}) begin
      failures++;
      $display("FAIL timeout_err got=%b/%0d exp=1/3", busy, cmderr);
    end
    reg_rsp_valid = 1'b1;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if ({busy, data0_wr_en} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_end got=%b/%b exp=0/0", busy, data0_wr_en);
    end
    cmderr_clr = 1'b1;
    tick();
    cmderr_clr = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_notsup();
    test_transfer0();
    test_halt_and_busy();
    test_rsp_err();
    test_reset_mid();
`ifdef DM_ABS_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
